// File: rtl/alog_pkg.sv
// Shared types for the adaptive-filter feeder: sample/accumulator widths,
// the buffered sample triplet and the frame sequencer state encoding.
// No logic; imported by the FIFO and the feeder top.
package alog_pkg;

  localparam int SAMPLE_W = 14;
  localparam int ACC_W    = 32;

  // One frame worth of samples: channel 2, channel 3, reference (42 bits).
  typedef struct packed {
    logic [SAMPLE_W-1:0] buf2;
    logic [SAMPLE_W-1:0] buf3;
    logic [SAMPLE_W-1:0] reff;
  } alog_triplet_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } alog_feed_state_e;

endpackage

// File: rtl/alog_triplet_fifo.sv
// Purpose: synchronous FIFO of sample triplets, count-based full/empty.
// Latency: written entry visible (empty low) right after the push edge; read data registered on the pop edge.
// Backpressure: ready is registered and drops on the edge of the filling push; pop only when not empty.
module alog_triplet_fifo
  import alog_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  alog_triplet_t wr_data,
  output logic          ready,
  input  logic          pop,
  output alog_triplet_t rd_data,
  output logic          empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  alog_triplet_t   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [AW:0]     count_nxt;

  assign empty = (count == '0);

  // Next occupancy; simultaneous push and pop cancel out.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Pointers, occupancy, registered ready and registered read port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready   <= 1'b1;
      rd_data <= '0;
    end else begin
      count <= count_nxt;
      ready <= (count_nxt != FULL_CNT);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/alog_feeder.sv
// Purpose: frame sequencer feeding sample triplets with head_flag framing to the filter top (optional capture: ALOG_FEEDER_CAPTURE_EN).
// Latency: triplet accepted at edge k into an idle, empty feeder -> head_flag high and data valid from edge k+2.
// Backpressure: s_ready is registered FIFO not-full; result stream has no backpressure.
module alog_feeder
  import alog_pkg::*;
#(
  parameter int HOLD_CYCLES = 20,
  parameter int GAP_CYCLES  = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_buf2,
  input  logic [SAMPLE_W-1:0] s_buf3,
  input  logic [SAMPLE_W-1:0] s_reff,
  output logic [SAMPLE_W-1:0] buffer_2,
  output logic [SAMPLE_W-1:0] buffer_3,
  output logic [SAMPLE_W-1:0] reff,
  output logic                head_flag,
`ifdef ALOG_FEEDER_CAPTURE_EN
  input  logic [ACC_W-1:0]    dout,
  output logic                res_valid,
  output logic [ACC_W-1:0]    res_data,
`endif
  output logic [15:0]         frame_cnt,
  output logic                busy
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
  // Pop one cycle ahead of the GAP exit so the next frame launches with no extra low time.
  localparam logic [7:0] GAP_PRE   = 8'(GAP_CYCLES - 2);

  alog_feed_state_e state;
  logic [7:0]       cnt;
  logic             fetched;
  logic             fifo_empty;
  logic             pop;
  logic             launch;
  logic             hold_end;
  logic             gap_end;
  logic             prefetch_pt;
  alog_triplet_t    wr_trip;
  alog_triplet_t    head_trip;

  assign wr_trip = '{buf2: s_buf2, buf3: s_buf3, reff: s_reff};

  alog_triplet_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (s_valid && s_ready),
    .wr_data (wr_trip),
    .ready   (s_ready),
    .pop     (pop),
    .rd_data (head_trip),
    .empty   (fifo_empty)
  );

  // Frame boundaries, the prefetch point and the pop/launch handshake with the FIFO read register.
  always_comb begin
    hold_end    = (state == ST_HOLD) && (cnt == HOLD_LAST);
    gap_end     = (state == ST_GAP) && (cnt == GAP_LAST);
    prefetch_pt = (GAP_CYCLES == 1) ? hold_end : ((state == ST_GAP) && (cnt == GAP_PRE));
    pop         = !fifo_empty && !fetched && ((state == ST_IDLE) || prefetch_pt);
    launch      = fetched && ((state == ST_IDLE) || gap_end);
  end

  assign busy = (state != ST_IDLE) || !fifo_empty || fetched;

  // State and cycle counter for the HOLD/GAP windows.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch) begin
            state <= ST_HOLD;
            cnt   <= '0;
          end
        end
        ST_HOLD: begin
          if (hold_end) begin
            state <= ST_GAP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_GAP: begin
          if (gap_end) begin
            state <= launch ? ST_HOLD : ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Marks that the FIFO read register holds a popped triplet awaiting launch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetched <= 1'b0;
    end else if (pop) begin
      fetched <= 1'b1;
    end else if (launch) begin
      fetched <= 1'b0;
    end
  end

  // Filter-facing samples, frame window and frame counter; samples only move on a launch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buffer_2  <= '0;
      buffer_3  <= '0;
      reff      <= '0;
      head_flag <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (launch) begin
        buffer_2  <= head_trip.buf2;
        buffer_3  <= head_trip.buf3;
        reff      <= head_trip.reff;
        head_flag <= 1'b1;
        frame_cnt <= frame_cnt + 16'd1;
      end else if (hold_end) begin
        head_flag <= 1'b0;
      end
    end
  end

`ifdef ALOG_FEEDER_CAPTURE_EN
  // Grab the filter output as the frame window closes and strobe it once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      res_valid <= hold_end;
      if (hold_end) res_data <= dout;
    end
  end
`endif

endmodule

// File: tb/tb_alog_feeder.sv
// Directed bench for alog_feeder: default instance (HOLD 20, GAP 2) and a GAP 1 instance.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
// Capture checks are compiled in when ALOG_FEEDER_CAPTURE_EN is defined.
module tb_alog_feeder;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;

  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [13:0] a_b2 = '0, a_b3 = '0, a_rf = '0;
  logic [13:0] b_b2 = '0, b_b3 = '0, b_rf = '0;
  logic        a_rdy, b_rdy, a_head, b_head, a_busy, b_busy;
  logic [13:0] a_o2, a_o3, a_orf, b_o2, b_o3, b_orf;
  logic [15:0] a_fc, b_fc;
`ifdef ALOG_FEEDER_CAPTURE_EN
  logic [31:0] a_dout = 32'hDEADBEEF, b_dout = 32'h0;
  logic        a_rv, b_rv;
  logic [31:0] a_rd, b_rd;
  int          res_pulses = 0;
  int          res_bad    = 0;
`endif

  int nvec = 0;
  int nmis = 0;

  logic [13:0] t2 [6];
  logic [13:0] t3 [6];
  logic [13:0] tr [6];

  always #5 clk = ~clk;

  alog_feeder u_a (
    .clk(clk), .rstn(rstn), .s_valid(a_valid), .s_ready(a_rdy),
    .s_buf2(a_b2), .s_buf3(a_b3), .s_reff(a_rf),
    .buffer_2(a_o2), .buffer_3(a_o3), .reff(a_orf), .head_flag(a_head),
`ifdef ALOG_FEEDER_CAPTURE_EN
    .dout(a_dout), .res_valid(a_rv), .res_data(a_rd),
`endif
    .frame_cnt(a_fc), .busy(a_busy)
  );

  alog_feeder #(.HOLD_CYCLES(20), .GAP_CYCLES(1), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rstn(rstn), .s_valid(b_valid), .s_ready(b_rdy),
    .s_buf2(b_b2), .s_buf3(b_b3), .s_reff(b_rf),
    .buffer_2(b_o2), .buffer_3(b_o3), .reff(b_orf), .head_flag(b_head),
`ifdef ALOG_FEEDER_CAPTURE_EN
    .dout(b_dout), .res_valid(b_rv), .res_data(b_rd),
`endif
    .frame_cnt(b_fc), .busy(b_busy)
  );

`ifdef ALOG_FEEDER_CAPTURE_EN
  always @(negedge clk) begin
    if (a_rv) begin
      res_pulses++;
      if (a_rd !== 32'hDEADBEEF) res_bad++;
    end
  end
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic head_of(input bit which);
    return which ? b_head : a_head;
  endfunction

  function automatic logic rdy_of(input bit which);
    return which ? b_rdy : a_rdy;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input bit which, input logic [13:0] v2, input logic [13:0] v3,
                      input logic [13:0] vr, output int waits);
    @(negedge clk);
    if (which) begin
      b_valid = 1'b1; b_b2 = v2; b_b3 = v3; b_rf = vr;
    end else begin
      a_valid = 1'b1; a_b2 = v2; a_b3 = v3; a_rf = vr;
    end
    waits = 0;
    while (!rdy_of(which) && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 200) chk("push_timeout", 1'b1, 1'b0);
    @(posedge clk);
  endtask

  task automatic idle(input bit which);
    @(negedge clk);
    if (which) b_valid = 1'b0;
    else a_valid = 1'b0;
  endtask

  task automatic wait_high(input bit which, input string tag);
    int i;
    i = 0;
    while (head_of(which) !== 1'b1 && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (i >= 200) chk(tag, 1'b0, 1'b1);
  endtask

  // Length of the current run at level lvl, counted in falling-edge samples.
  task automatic run_len(input bit which, input logic lvl, output int n);
    n = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (head_of(which) !== lvl) break;
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    int n;
    int nh;
    int nl;
    int wb [6];
    int highs;
`ifdef ALOG_FEEDER_CAPTURE_EN
    int res0;
`endif

    for (int i = 0; i < 6; i++) begin
      t2[i] = 14'h0100 + 14'(i);
      t3[i] = 14'h2A00 + 14'(i * 3);
      tr[i] = 14'h3FF0 - 14'(i);
    end

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_head", a_head, 1'b0);
    chk("rst_ready", a_rdy, 1'b1);
    chk("rst_buf2", a_o2, 14'h0);
    chk("rst_reff", a_orf, 14'h0);
    chk("rst_fcnt", a_fc, 16'h0);
    chk("rst_busy", a_busy, 1'b0);
`ifdef ALOG_FEEDER_CAPTURE_EN
    chk("rst_resv", a_rv, 1'b0);
    chk("rst_resd", a_rd, 32'h0);
`endif
    rstn = 1'b1;
    @(negedge clk);

    // Single triplet: accepted at edge k, head_flag from k+2 for 20 cycles.
    push(0, 14'h0123, 14'h0456, 14'h1FFF, w);
    idle(0);
    chk("t1_head_k", a_head, 1'b0);
    chk("t1_busy_k", a_busy, 1'b1);
    @(negedge clk);
    chk("t1_head_k1", a_head, 1'b0);
    @(negedge clk);
    chk("t1_head_k2", a_head, 1'b1);
    chk("t1_buf2", a_o2, 14'h0123);
    chk("t1_buf3", a_o3, 14'h0456);
    chk("t1_reff", a_orf, 14'h1FFF);
    chk("t1_fcnt", a_fc, 16'd1);
    run_len(0, 1'b1, n);
    chk("t1_high_len", n, 20);
`ifdef ALOG_FEEDER_CAPTURE_EN
    chk("t1_resv", a_rv, 1'b1);
    chk("t1_resd", a_rd, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_resv_once", a_rv, 1'b0);
`endif
    chk("t1_buf_hold", a_o2, 14'h0123);
    repeat (5) @(negedge clk);
    chk("t1_idle_busy", a_busy, 1'b0);

    // Burst of six: five accepted before ready drops, frames in order, 2-cycle gaps.
    do_reset();
`ifdef ALOG_FEEDER_CAPTURE_EN
    res0 = res_pulses;
`endif
    fork
      begin
        for (int i = 0; i < 6; i++) push(0, t2[i], t3[i], tr[i], wb[i]);
        idle(0);
      end
      begin
        wait_high(0, "burst_first_timeout");
        for (int f = 0; f < 6; f++) begin
          chk($sformatf("burst_f%0d_buf2", f), a_o2, t2[f]);
          chk($sformatf("burst_f%0d_buf3", f), a_o3, t3[f]);
          chk($sformatf("burst_f%0d_reff", f), a_orf, tr[f]);
          run_len(0, 1'b1, n);
          chk($sformatf("burst_f%0d_high", f), n, 20);
          if (f < 5) begin
            run_len(0, 1'b0, n);
            chk($sformatf("burst_f%0d_gap", f), n, 2);
          end
        end
      end
    join
    chk("burst_no_wait_first5", wb[0] + wb[1] + wb[2] + wb[3] + wb[4], 0);
    chk("burst_ready_drop", wb[5] > 0, 1'b1);
    chk("burst_fcnt", a_fc, 16'd6);
`ifdef ALOG_FEEDER_CAPTURE_EN
    repeat (3) @(negedge clk);
    chk("cap_pulses", res_pulses - res0, 6);
    chk("cap_bad", res_bad, 0);
`endif

    // Reset mid-frame with two entries queued.
    do_reset();
    push(0, 14'h0011, 14'h0022, 14'h0033, w);
    push(0, 14'h0044, 14'h0055, 14'h0066, w);
    push(0, 14'h0077, 14'h0088, 14'h0099, w);
    idle(0);
    wait_high(0, "midrst_launch_timeout");
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst_head_async", a_head, 1'b0);
    chk("midrst_fcnt", a_fc, 16'd0);
    @(negedge clk);
    rstn = 1'b1;
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_head) highs++;
    end
    chk("midrst_no_frame", highs, 0);
    chk("midrst_busy", a_busy, 1'b0);
    chk("midrst_ready", a_rdy, 1'b1);

    // Frame counter wrap.
    do_reset();
    force u_a.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release u_a.frame_cnt;
    push(0, 14'h0abc, 14'h0def, 14'h0123, w);
    idle(0);
    wait_high(0, "wrap_launch_timeout");
    chk("wrap_fcnt", a_fc, 16'h0000);

    // GAP_CYCLES = 1: three frames, one low cycle between, period 21.
    do_reset();
    for (int i = 0; i < 3; i++) push(1, t2[i], t3[i], tr[i], w);
    idle(1);
    wait_high(1, "gap1_launch_timeout");
    for (int f = 0; f < 3; f++) begin
      chk($sformatf("gap1_f%0d_buf2", f), b_o2, t2[f]);
      run_len(1, 1'b1, nh);
      chk($sformatf("gap1_f%0d_high", f), nh, 20);
      if (f < 2) begin
        run_len(1, 1'b0, nl);
        chk($sformatf("gap1_f%0d_low", f), nl, 1);
        chk($sformatf("gap1_f%0d_period", f), nh + nl, 21);
      end
    end
    chk("gap1_fcnt", b_fc, 16'd3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
